// File: rtl/fc_l2_port_arbiter.sv
// fc_l2_port_arbiter: shares one TCDM master port between two requesters.
// Fixed priority (port 0 first), in-order response routing through a small FIFO
// of port IDs. Optional port-1 starvation promotion is enabled by defining the
// macro FC_ARB_STARVE_CNT_EN; the default build keeps strict port-0 priority.
module fc_l2_port_arbiter #(
  parameter int MAX_OUTSTANDING = 2,
  parameter int STARVE_LIMIT    = 8,
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [1:0]                   s_req_i,
  input  logic [1:0][ADDR_WIDTH-1:0]   s_add_i,
  input  logic [1:0]                   s_wen_i,
  input  logic [1:0][DATA_WIDTH-1:0]   s_wdata_i,
  input  logic [1:0][DATA_WIDTH/8-1:0] s_be_i,
  output logic [1:0]                   s_gnt_o,
  output logic [1:0]                   s_r_valid_o,
  output logic [DATA_WIDTH-1:0]        s_r_rdata_o,
  output logic                         s_r_opc_o,
  output logic                         m_req_o,
  output logic [ADDR_WIDTH-1:0]        m_add_o,
  output logic                         m_wen_o,
  output logic [DATA_WIDTH-1:0]        m_wdata_o,
  output logic [DATA_WIDTH/8-1:0]      m_be_o,
  input  logic                         m_gnt_i,
  input  logic                         m_r_valid_i,
  input  logic [DATA_WIDTH-1:0]        m_r_rdata_i,
  input  logic                         m_r_opc_i,
  output logic [3:0]                   outstanding_o,
  output logic                         spurious_rsp_o
);

  localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(MAX_OUTSTANDING - 1);
  localparam logic [3:0]       FULL_CNT = 4'(MAX_OUTSTANDING);

  logic [PTR_W-1:0]           wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]           rd_ptr_q, rd_ptr_d;
  logic [3:0]                 cnt_q, cnt_d;
  logic [MAX_OUTSTANDING-1:0] fifo_q, fifo_d;
  logic                       full, empty, sel, push, pop;

`ifdef FC_ARB_STARVE_CNT_EN
  localparam int SC_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [SC_W-1:0] LIMIT = SC_W'(STARVE_LIMIT);

  logic [SC_W-1:0] starve_cnt_q, starve_cnt_d;
  logic            promote_q, promote_d;

  // Port select: port 1 wins when promoted and still requesting, else port 0 first.
  always_comb sel = (promote_q & s_req_i[1]) | ~s_req_i[0];

  // Count denied port-1 cycles (saturating); promote once the limit is reached.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    promote_d    = promote_q;
    if (s_gnt_o[1]) begin
      starve_cnt_d = '0;
      promote_d    = 1'b0;
    end else if (s_req_i[1]) begin
      if (starve_cnt_q != LIMIT) starve_cnt_d = starve_cnt_q + SC_W'(1);
      if (starve_cnt_d == LIMIT) promote_d = 1'b1;
    end else begin
      starve_cnt_d = '0;
    end
  end

  // Starvation state register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      starve_cnt_q <= '0;
      promote_q    <= 1'b0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      promote_q    <= promote_d;
    end
  end
`else
  // Port select: strict priority, port 1 only when port 0 is idle.
  always_comb sel = ~s_req_i[0];
`endif

  // Request path: forward the selected port, hold off while the routing FIFO is full.
  always_comb begin
    full      = (cnt_q == FULL_CNT);
    m_req_o   = ~rst_i & ~full & (|s_req_i);
    m_add_o   = s_add_i[sel];
    m_wen_o   = s_wen_i[sel];
    m_wdata_o = s_wdata_i[sel];
    m_be_o    = s_be_i[sel];
    push      = m_req_o & m_gnt_i;
    s_gnt_o   = 2'b00;
    if (push) s_gnt_o[sel] = 1'b1;
  end

  // Response path: zero-latency routing to the port at the FIFO head.
  always_comb begin
    empty          = (cnt_q == 4'd0);
    pop            = ~rst_i & m_r_valid_i & ~empty;
    spurious_rsp_o = ~rst_i & m_r_valid_i & empty;
    s_r_rdata_o    = m_r_rdata_i;
    s_r_opc_o      = m_r_opc_i;
    s_r_valid_o    = 2'b00;
    if (pop) s_r_valid_o[fifo_q[rd_ptr_q]] = 1'b1;
  end

  // Routing FIFO next state; pointers wrap at MAX_OUTSTANDING.
  always_comb begin
    fifo_d   = fifo_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push) begin
      fifo_d[wr_ptr_q] = sel;
      wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 4'd1;
      2'b01:   cnt_d = cnt_q - 4'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  // Routing FIFO registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fifo_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      fifo_q   <= fifo_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  assign outstanding_o = cnt_q;

endmodule

// File: tb/tb_fc_l2_port_arbiter.sv
// Self-checking bench for fc_l2_port_arbiter: directed scenarios followed by
// randomized traffic, all checked against a queue-based reference model.
module tb_fc_l2_port_arbiter;
  localparam int MAXO  = 2;
  localparam int LIMIT = 8;
  localparam int AW    = 32;
  localparam int DW    = 32;

  logic                 clk_i = 1'b0;
  logic                 rst_i;
  logic [1:0]           s_req_i;
  logic [1:0][AW-1:0]   s_add_i;
  logic [1:0]           s_wen_i;
  logic [1:0][DW-1:0]   s_wdata_i;
  logic [1:0][DW/8-1:0] s_be_i;
  logic [1:0]           s_gnt_o;
  logic [1:0]           s_r_valid_o;
  logic [DW-1:0]        s_r_rdata_o;
  logic                 s_r_opc_o;
  logic                 m_req_o;
  logic [AW-1:0]        m_add_o;
  logic                 m_wen_o;
  logic [DW-1:0]        m_wdata_o;
  logic [DW/8-1:0]      m_be_o;
  logic                 m_gnt_i;
  logic                 m_r_valid_i;
  logic [DW-1:0]        m_r_rdata_i;
  logic                 m_r_opc_i;
  logic [3:0]           outstanding_o;
  logic                 spurious_rsp_o;

  always #5 clk_i = ~clk_i;

  fc_l2_port_arbiter #(
    .MAX_OUTSTANDING(MAXO), .STARVE_LIMIT(LIMIT), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .s_req_i(s_req_i), .s_add_i(s_add_i), .s_wen_i(s_wen_i),
    .s_wdata_i(s_wdata_i), .s_be_i(s_be_i),
    .s_gnt_o(s_gnt_o), .s_r_valid_o(s_r_valid_o),
    .s_r_rdata_o(s_r_rdata_o), .s_r_opc_o(s_r_opc_o),
    .m_req_o(m_req_o), .m_add_o(m_add_o), .m_wen_o(m_wen_o),
    .m_wdata_o(m_wdata_o), .m_be_o(m_be_o),
    .m_gnt_i(m_gnt_i), .m_r_valid_i(m_r_valid_i),
    .m_r_rdata_i(m_r_rdata_i), .m_r_opc_i(m_r_opc_i),
    .outstanding_o(outstanding_o), .spurious_rsp_o(spurious_rsp_o)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: queue of port IDs awaiting a response, plus starvation bookkeeping.
  int q[$];
  int wait_cnt = 0;
  bit promoted = 1'b0;

  logic [1:0]    obs_gnt, obs_rv;
  logic          obs_spur, obs_mreq;
  logic [3:0]    obs_out;
  logic [DW-1:0] obs_rdata;
  logic [AW-1:0] obs_add;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, check outputs against the model, advance the model.
  task automatic step(input logic rst, input logic [1:0] req, input logic mg,
                      input logic rv, input logic [DW-1:0] rd, input logic [AW-1:0] a0);
    int         sel;
    bit         full, e_mreq, e_spur;
    logic [1:0] e_gnt, e_rv;
    @(negedge clk_i);
    rst_i        = rst;
    s_req_i      = req;
    s_add_i[0]   = a0;
    s_add_i[1]   = $urandom;
    s_wen_i      = 2'($urandom);
    s_wdata_i[0] = $urandom;
    s_wdata_i[1] = $urandom;
    s_be_i       = 8'($urandom);
    m_gnt_i      = mg;
    m_r_valid_i  = rv;
    m_r_rdata_i  = rd;
    m_r_opc_i    = 1'($urandom);
    #1;
    full   = (q.size() == MAXO);
    sel    = (req[0] && !(promoted && req[1])) ? 0 : 1;
    e_mreq = !rst && !full && (req != 2'b00);
    e_gnt  = (e_mreq && mg) ? (2'b01 << sel) : 2'b00;
    e_rv   = (!rst && rv && q.size() > 0) ? (2'b01 << q[0]) : 2'b00;
    e_spur = !rst && rv && (q.size() == 0);
    chk("m_req", m_req_o, e_mreq);
    chk("s_gnt", s_gnt_o, e_gnt);
    chk("s_r_valid", s_r_valid_o, e_rv);
    chk("spurious", spurious_rsp_o, e_spur);
    chk("outstanding", outstanding_o, q.size());
    if (e_mreq) begin
      chk("m_add", m_add_o, s_add_i[sel]);
      chk("m_wen", m_wen_o, s_wen_i[sel]);
      chk("m_wdata", m_wdata_o, s_wdata_i[sel]);
      chk("m_be", m_be_o, s_be_i[sel]);
    end
    if (e_rv != 2'b00) begin
      chk("s_r_rdata", s_r_rdata_o, rd);
      chk("s_r_opc", s_r_opc_o, m_r_opc_i);
    end
    obs_gnt   = s_gnt_o;
    obs_rv    = s_r_valid_o;
    obs_spur  = spurious_rsp_o;
    obs_mreq  = m_req_o;
    obs_out   = outstanding_o;
    obs_rdata = s_r_rdata_o;
    obs_add   = m_add_o;
    @(posedge clk_i);
    if (rst) begin
      q.delete();
      wait_cnt = 0;
      promoted = 1'b0;
    end else begin
      if (e_rv != 2'b00) void'(q.pop_front());
      if (e_gnt != 2'b00) q.push_back(sel);
`ifdef FC_ARB_STARVE_CNT_EN
      if (e_gnt[1]) begin
        wait_cnt = 0;
        promoted = 1'b0;
      end else if (req[1]) begin
        wait_cnt++;
        if (wait_cnt >= LIMIT) promoted = 1'b1;
      end else begin
        wait_cnt = 0;
      end
`endif
    end
  endtask

  task automatic idle();
    step(1'b0, 2'b00, 1'b0, 1'b0, $urandom, $urandom);
  endtask

  initial begin
    rst_i = 1'b1; s_req_i = '0; s_add_i = '0; s_wen_i = '1; s_wdata_i = '0; s_be_i = '0;
    m_gnt_i = 1'b0; m_r_valid_i = 1'b0; m_r_rdata_i = '0; m_r_opc_i = 1'b0;

    // Reset with busy inputs: everything quiet.
    step(1'b1, 2'b11, 1'b1, 1'b1, $urandom, $urandom);
    step(1'b1, 2'b11, 1'b1, 1'b1, $urandom, $urandom);
    chk("rst_mreq", obs_mreq, 1'b0);
    chk("rst_gnt", obs_gnt, 2'b00);
    chk("rst_spur", obs_spur, 1'b0);

    // Single read from port 0.
    step(1'b0, 2'b01, 1'b1, 1'b0, $urandom, 32'h1C00_0010);
    chk("rd_gnt", obs_gnt, 2'b01);
    chk("rd_addr", obs_add, 32'h1C00_0010);
    idle();
    chk("rd_out1", obs_out, 4'd1);
    step(1'b0, 2'b00, 1'b0, 1'b1, 32'hDEAD_BEEF, $urandom);
    chk("rd_rvalid", obs_rv, 2'b01);
    chk("rd_rdata", obs_rdata, 32'hDEAD_BEEF);
    idle();
    chk("rd_out0", obs_out, 4'd0);

    // Simultaneous requests: port 0 wins, port 1 waits with a changing address.
    step(1'b0, 2'b11, 1'b1, 1'b0, $urandom, $urandom);
    chk("pri_gnt1", obs_gnt, 2'b01);
    step(1'b0, 2'b11, 1'b1, 1'b1, $urandom, $urandom);
    chk("pri_gnt2", obs_gnt, 2'b01);
    step(1'b0, 2'b11, 1'b1, 1'b1, $urandom, $urandom);
    chk("pri_gnt3", obs_gnt, 2'b01);
    step(1'b0, 2'b10, 1'b1, 1'b1, $urandom, $urandom);
    chk("pri_gnt_p1", obs_gnt, 2'b10);
    step(1'b0, 2'b00, 1'b0, 1'b1, $urandom, $urandom);
    chk("pri_rv_p1", obs_rv, 2'b10);

    // FIFO full: blocked even with a response in the same cycle.
    step(1'b0, 2'b01, 1'b1, 1'b0, $urandom, $urandom);
    step(1'b0, 2'b01, 1'b1, 1'b0, $urandom, $urandom);
    step(1'b0, 2'b01, 1'b1, 1'b0, $urandom, $urandom);
    chk("full_mreq", obs_mreq, 1'b0);
    chk("full_gnt", obs_gnt, 2'b00);
    step(1'b0, 2'b01, 1'b1, 1'b1, $urandom, $urandom);
    chk("full_rsp_gnt", obs_gnt, 2'b00);
    chk("full_rsp_rv", obs_rv, 2'b01);
    step(1'b0, 2'b01, 1'b1, 1'b0, $urandom, $urandom);
    chk("full_resume", obs_gnt, 2'b01);
    step(1'b0, 2'b00, 1'b0, 1'b1, $urandom, $urandom);
    step(1'b0, 2'b00, 1'b0, 1'b1, $urandom, $urandom);
    idle();
    chk("full_drained", obs_out, 4'd0);

    // Ordering: port 1 then port 0, with a push and pop in the same cycle.
    step(1'b0, 2'b10, 1'b1, 1'b0, $urandom, $urandom);
    chk("ord_gnt_p1", obs_gnt, 2'b10);
    step(1'b0, 2'b01, 1'b1, 1'b1, $urandom, $urandom);
    chk("ord_gnt_p0", obs_gnt, 2'b01);
    chk("ord_rv_p1", obs_rv, 2'b10);
    step(1'b0, 2'b00, 1'b0, 1'b1, $urandom, $urandom);
    chk("ord_pushpop_out", obs_out, 4'd1);
    chk("ord_rv_p0", obs_rv, 2'b01);
    idle();
    chk("ord_out0", obs_out, 4'd0);

    // Spurious responses, including ones for transfers issued before a reset.
    step(1'b0, 2'b00, 1'b0, 1'b1, $urandom, $urandom);
    chk("spur_pulse", obs_spur, 1'b1);
    chk("spur_rv", obs_rv, 2'b00);
    idle();
    chk("spur_one_cycle", obs_spur, 1'b0);
    chk("spur_out0", obs_out, 4'd0);
    step(1'b0, 2'b01, 1'b1, 1'b0, $urandom, $urandom);
    step(1'b0, 2'b01, 1'b1, 1'b0, $urandom, $urandom);
    idle();
    chk("spur_out2", obs_out, 4'd2);
    step(1'b1, 2'b00, 1'b0, 1'b0, $urandom, $urandom);
    step(1'b0, 2'b00, 1'b0, 1'b1, $urandom, $urandom);
    chk("spur_after_rst1", obs_spur, 1'b1);
    step(1'b0, 2'b00, 1'b0, 1'b1, $urandom, $urandom);
    chk("spur_after_rst2", obs_spur, 1'b1);
    chk("spur_after_rst_rv", obs_rv, 2'b00);
    idle();

`ifdef FC_ARB_STARVE_CNT_EN
    // Starvation: port 1 promoted after LIMIT denied cycles, then port 0 again.
    for (int i = 0; i < LIMIT; i++) begin
      step(1'b0, 2'b11, 1'b1, 1'b1, $urandom, $urandom);
      chk("starve_denied", obs_gnt, 2'b01);
    end
    step(1'b0, 2'b11, 1'b1, 1'b1, $urandom, $urandom);
    chk("starve_promoted", obs_gnt, 2'b10);
    step(1'b0, 2'b11, 1'b1, 1'b1, $urandom, $urandom);
    chk("starve_back_p0", obs_gnt, 2'b01);
    step(1'b0, 2'b00, 1'b0, 1'b1, $urandom, $urandom);
    idle();
`endif

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 63) == 0), 2'($urandom), ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 2) != 0), $urandom, $urandom);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
